sa_chunked_addsub: RTL and testbench

Parametrised chunk-serial adder/subtractor: two operands of `CHUNK_W*NUM_CHUNKS` bits arrive least-significant chunk first over narrow buses, and one carry is chained between chunks. It generalises the fixed 48-bit, 4×12-bit serial adder in three ways: configurable width and chunk count, a subtract mode, and a per-chunk valid qualifier that tolerates input gaps. It reports carry-out, signed overflow and a one-cycle completion strobe.

---
 rtl/sa_chunked_addsub.sv | 131 +++++++++++++
 tb/tb_sa_chunked_addsub.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_chunked_addsub.sv
// Chunk-serial adder/subtractor.
// Operands of CHUNK_W*NUM_CHUNKS bits arrive least-significant chunk first.
// One carry (or, in subtract mode, an inverted borrow) is chained between chunks.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   inBusA, inBusB      operand chunks (CHUNK_W bits)
//   inValid             chunk on the buses is valid this cycle
//   startChunks         marks chunk 0 (qualified by inValid)
//   sub, ci             mode (1 = A-B-ci) and carry/borrow-in, sampled with chunk 0
//   outBus              last completed RW-bit result
//   co, ovf             raw carry-out of the final chunk, signed overflow
//   resultReady         one-cycle completion strobe
//   busy                chunks 1..N-1 of an operation are pending
module sa_chunked_addsub #(
  parameter int unsigned CHUNK_W    = 12,
  parameter int unsigned NUM_CHUNKS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHUNK_W-1:0]            inBusA,
  input  logic [CHUNK_W-1:0]            inBusB,
  input  logic                          inValid,
  input  logic                          startChunks,
  input  logic                          sub,
  input  logic                          ci,
  output logic [CHUNK_W*NUM_CHUNKS-1:0] outBus,
  output logic                          co,
  output logic                          ovf,
  output logic                          resultReady,
  output logic                          busy
);

  localparam int unsigned RW   = CHUNK_W * NUM_CHUNKS;
  localparam int unsigned IW   = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int unsigned LAST = NUM_CHUNKS - 1;

  typedef enum logic {
    S_IDLE,
    S_ACCUM
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_idx;
  logic            r_cr;
  logic            r_m;
  logic [RW-1:0]   r_shadow;
  logic [RW-1:0]   r_out;
  logic            r_co;
  logic            r_ovf;
  logic            r_ready;
  logic            r_busy;

  logic            w_start;
  logic            w_accept;
  logic            w_last;
  logic            w_m;
  logic            w_cin;
  logic [IW-1:0]   w_k;
  logic [IW-1:0]   w_idx_nxt;
  logic [CHUNK_W-1:0] w_b;
  logic [CHUNK_W:0]   w_sum;
  logic            w_msb_cin;
  logic [RW-1:0]   w_full;

  always_comb begin
    w_start     = inValid & startChunks;
    // A start chunk is always taken, even mid-operation (restart discards the old one).
    w_accept    = inValid & (w_start | (r_state == S_ACCUM));
    w_m         = w_start ? sub : r_m;
    w_cin       = w_start ? (sub ? ~ci : ci) : r_cr;
    w_k         = w_start ? '0 : r_idx;
    w_b         = w_m ? ~inBusB : inBusB;
    w_sum       = {1'b0, inBusA} + {1'b0, w_b} + {{CHUNK_W{1'b0}}, w_cin};
    // Carry into the result MSB recovered from the MSB sum bit.
    w_msb_cin   = inBusA[CHUNK_W-1] ^ w_b[CHUNK_W-1] ^ w_sum[CHUNK_W-1];
    w_last      = w_accept & (w_k == IW'(LAST));
    w_full      = r_shadow;
    w_full[w_k*CHUNK_W +: CHUNK_W] = w_sum[CHUNK_W-1:0];

    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (w_accept) begin
      if (w_last) begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end else begin
        w_state_nxt = S_ACCUM;
        w_idx_nxt   = w_k + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_cr     <= 1'b0;
      r_m      <= 1'b0;
      r_shadow <= '0;
      r_out    <= '0;
      r_co     <= 1'b0;
      r_ovf    <= 1'b0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_ready <= w_last;
      r_busy  <= (w_state_nxt == S_ACCUM);
      if (w_accept) begin
        r_cr     <= w_sum[CHUNK_W];
        r_m      <= w_m;
        r_shadow <= w_full;
      end
      if (w_last) begin
        r_out <= w_full;
        r_co  <= w_sum[CHUNK_W];
        r_ovf <= w_msb_cin ^ w_sum[CHUNK_W];
      end
    end
  end

  assign outBus      = r_out;
  assign co          = r_co;
  assign ovf         = r_ovf;
  assign resultReady = r_ready;
  assign busy        = r_busy;

endmodule

// File: tb/tb_sa_chunked_addsub.sv
// Bench for sa_chunked_addsub: three instances (12x4, 8x1, 4x6) share one
// clock and reset. An arithmetic reference model predicts each result; a single
// compare process checks strobe timing, results and output holding every cycle.
module tb_sa_chunked_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance 0: CHUNK_W=12, NUM_CHUNKS=4
  logic [11:0] a0, b0;
  logic        v0, st0, s0, c0;
  logic [47:0] out0;
  logic        co0, ov0, rr0, bz0;
  // instance 1: CHUNK_W=8, NUM_CHUNKS=1
  logic [7:0]  a1, b1;
  logic        v1, st1, s1, c1;
  logic [7:0]  out1;
  logic        co1, ov1, rr1, bz1;
  // instance 2: CHUNK_W=4, NUM_CHUNKS=6
  logic [3:0]  a2, b2;
  logic        v2, st2, s2, c2;
  logic [23:0] out2;
  logic        co2, ov2, rr2, bz2;

  sa_chunked_addsub #(.CHUNK_W(12), .NUM_CHUNKS(4)) u0 (
    .clk(clk), .rst(rst), .inBusA(a0), .inBusB(b0), .inValid(v0), .startChunks(st0),
    .sub(s0), .ci(c0), .outBus(out0), .co(co0), .ovf(ov0), .resultReady(rr0), .busy(bz0));
  sa_chunked_addsub #(.CHUNK_W(8), .NUM_CHUNKS(1)) u1 (
    .clk(clk), .rst(rst), .inBusA(a1), .inBusB(b1), .inValid(v1), .startChunks(st1),
    .sub(s1), .ci(c1), .outBus(out1), .co(co1), .ovf(ov1), .resultReady(rr1), .busy(bz1));
  sa_chunked_addsub #(.CHUNK_W(4), .NUM_CHUNKS(6)) u2 (
    .clk(clk), .rst(rst), .inBusA(a2), .inBusB(b2), .inValid(v2), .startChunks(st2),
    .sub(s2), .ci(c2), .outBus(out2), .co(co2), .ovf(ov2), .resultReady(rr2), .busy(bz2));

  int n_tests = 0;
  int n_fail  = 0;
  longint cyc = 0;
  int cw[3] = '{12, 8, 4};
  int nc[3] = '{4, 1, 6};

  typedef struct {
    int          inst;
    longint      due;
    logic [47:0] out;
    bit          co;
    bit          ov;
  } exp_t;
  exp_t q[$];

  logic [47:0] last_out[3];
  bit          last_co[3];
  bit          last_ov[3];

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on RW-bit operands.
  function automatic void model(input logic [47:0] a, input logic [47:0] b, input bit s,
                                input bit c, input int rw, output logic [47:0] r,
                                output bit co, output bit ov);
    longint unsigned m, ua, ub, t;
    longint sa, sb, sr, hi, lo;
    m  = (64'd1 << rw) - 64'd1;
    ua = 64'(a) & m;
    ub = 64'(b) & m;
    if (s) begin
      co = (ua >= ub + 64'(c));
      t  = (ua - ub - 64'(c)) & m;
    end else begin
      t  = ua + ub + 64'(c);
      co = ((t >> rw) != 0);
      t  = t & m;
    end
    r  = t[47:0];
    sa = ua[rw-1] ? longint'(ua) - longint'(64'd1 << rw) : longint'(ua);
    sb = ub[rw-1] ? longint'(ub) - longint'(64'd1 << rw) : longint'(ub);
    sr = s ? (sa - sb - longint'(c)) : (sa + sb + longint'(c));
    hi = longint'(64'd1 << (rw - 1)) - 1;
    lo = -hi - 1;
    ov = (sr > hi) || (sr < lo);
  endfunction

  task automatic drive(input int inst, input bit v, input bit st, input bit s, input bit c,
                       input logic [47:0] ca, input logic [47:0] cb);
    case (inst)
      0: begin v0 = v; st0 = st; s0 = s; c0 = c; a0 = ca[11:0]; b0 = cb[11:0]; end
      1: begin v1 = v; st1 = st; s1 = s; c1 = c; a1 = ca[7:0];  b1 = cb[7:0];  end
      default: begin v2 = v; st2 = st; s2 = s; c2 = c; a2 = ca[3:0]; b2 = cb[3:0]; end
    endcase
  endtask

  function automatic bit busy_of(input int inst);
    case (inst)
      0:       return bz0;
      1:       return bz1;
      default: return bz2;
    endcase
  endfunction

  // Presents chunks 0..min(stop_at,N)-1; inputs are left driven (no trailing bubble).
  task automatic run_op(input int inst, input logic [47:0] a, input logic [47:0] b,
                        input bit s, input bit c, input int gap_at, input int gap_len,
                        input int stop_at, input bit has_exp, input logic [47:0] eo,
                        input bit eco, input bit eov);
    int n = nc[inst];
    int w = cw[inst];
    int lim = (stop_at < n) ? stop_at : n;
    logic [47:0] m = (48'd1 << w) - 48'd1;
    for (int k = 0; k < lim; k++) begin
      if (k == gap_at && k > 0) begin
        for (int g = 0; g < gap_len; g++) begin
          @(posedge clk); #1;
          check($sformatf("busy_gap_i%0d", inst), 64'(busy_of(inst)), 64'd1);
          drive(inst, 1'b0, 1'b0, s, c, 48'h0, 48'h0);
        end
      end
      @(posedge clk); #1;
      if (k > 0) check($sformatf("busy_mid_i%0d", inst), 64'(busy_of(inst)), 64'd1);
      drive(inst, 1'b1, (k == 0), s, c, (a >> (k * w)) & m, (b >> (k * w)) & m);
      if (k == n - 1 && has_exp) q.push_back('{inst, cyc + 1, eo, eco, eov});
    end
  endtask

  task automatic run_model(input int inst, input logic [47:0] a, input logic [47:0] b,
                           input bit s, input bit c, input int gap_at, input int gap_len);
    logic [47:0] r;
    bit co, ov;
    model(a, b, s, c, cw[inst] * nc[inst], r, co, ov);
    run_op(inst, a, b, s, c, gap_at, gap_len, 99, 1'b1, r, co, ov);
  endtask

  // Idle cycles; optionally with inValid high but no start, which must be ignored.
  task automatic idle(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      for (int j = 0; j < 3; j++) begin
        check($sformatf("busy_idle_i%0d", j), 64'(busy_of(j)), 64'd0);
        drive(j, stray, 1'b0, 1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
      end
    end
  endtask

  function automatic logic [47:0] pick(input int rw);
    logic [47:0] m = 48'((64'd1 << rw) - 64'd1);
    case ($urandom_range(0, 4))
      0:       return m;
      1:       return 48'(64'd1 << (rw - 1));
      2:       return 48'(64'd1 << (rw - 1)) - 48'd1;
      default: return {$urandom, $urandom} & m;
    endcase
  endfunction

  // Single compare process: strobe timing, result values, and holding between results.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [47:0] o;
      bit r, c, v, due;
      case (i)
        0:       begin o = out0;          r = rr0; c = co0; v = ov0; end
        1:       begin o = {40'h0, out1}; r = rr1; c = co1; v = ov1; end
        default: begin o = {24'h0, out2}; r = rr2; c = co2; v = ov2; end
      endcase
      if (rst) begin
        last_out[i] = '0; last_co[i] = 1'b0; last_ov[i] = 1'b0;
        check($sformatf("rst_out_i%0d", i), 64'(o), 64'd0);
        check($sformatf("rst_flags_i%0d", i), {61'd0, r, c, v}, 64'd0);
      end else begin
        due = (q.size() > 0) && (q[0].inst == i) && (q[0].due == cyc);
        if (due) begin
          check($sformatf("strobe_i%0d", i), 64'(r), 64'd1);
          check($sformatf("result_i%0d", i), 64'(o), 64'(q[0].out));
          check($sformatf("co_i%0d", i), 64'(c), 64'(q[0].co));
          check($sformatf("ovf_i%0d", i), 64'(v), 64'(q[0].ov));
          last_out[i] = q[0].out; last_co[i] = q[0].co; last_ov[i] = q[0].ov;
          void'(q.pop_front());
        end else begin
          check($sformatf("no_strobe_i%0d", i), 64'(r), 64'd0);
          check($sformatf("hold_out_i%0d", i), 64'(o), 64'(last_out[i]));
          check($sformatf("hold_flags_i%0d", i), {62'd0, c, v}, {62'd0, last_co[i], last_ov[i]});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] r;
    bit co, ov;
    for (int j = 0; j < 3; j++) drive(j, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0, 48'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2, 1'b0);

    // Pin the reference model with hand-worked cases.
    model(48'hFFFF_FFFF_FFFF, 48'h1, 1'b0, 1'b0, 48, r, co, ov);
    check("model_ripple", {r, 14'd0, co, ov}, {48'h0, 14'd0, 1'b1, 1'b0});
    model(48'h0, 48'h1, 1'b1, 1'b0, 48, r, co, ov);
    check("model_borrow", {r, 14'd0, co, ov}, {48'hFFFF_FFFF_FFFF, 14'd0, 1'b0, 1'b0});
    model(48'h7FFF_FFFF_FFFF, 48'h1, 1'b0, 1'b0, 48, r, co, ov);
    check("model_posovf", {r, 14'd0, co, ov}, {48'h8000_0000_0000, 14'd0, 1'b0, 1'b1});
    model(48'h8000_0000_0000, 48'h1, 1'b1, 1'b0, 48, r, co, ov);
    check("model_negovf", {r, 14'd0, co, ov}, {48'h7FFF_FFFF_FFFF, 14'd0, 1'b1, 1'b1});
    model(48'h5, 48'h3, 1'b1, 1'b1, 48, r, co, ov);
    check("model_subci", {r, 14'd0, co, ov}, {48'h1, 14'd0, 1'b1, 1'b0});
    model(48'hF0, 48'h20, 1'b0, 1'b1, 8, r, co, ov);
    check("model_w8", {r, 14'd0, co, ov}, {48'h11, 14'd0, 1'b1, 1'b0});

    // Directed vectors with hand-computed results on the 12x4 instance.
    run_op(0, 48'hFFFF_FFFF_FFFF, 48'h1, 1'b0, 1'b0, 0, 0, 99, 1'b1, 48'h0, 1'b1, 1'b0);
    idle(2, 1'b1);
    run_op(0, 48'h0, 48'h1, 1'b1, 1'b0, 0, 0, 99, 1'b1, 48'hFFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_op(0, 48'h5, 48'h3, 1'b1, 1'b1, 0, 0, 99, 1'b1, 48'h1, 1'b1, 1'b0);
    run_op(0, 48'h7FFF_FFFF_FFFF, 48'h1, 1'b0, 1'b0, 0, 0, 99, 1'b1, 48'h8000_0000_0000, 1'b0, 1'b1);
    run_op(0, 48'h8000_0000_0000, 48'h1, 1'b1, 1'b0, 0, 0, 99, 1'b1, 48'h7FFF_FFFF_FFFF, 1'b1, 1'b1);
    idle(1, 1'b0);
    run_op(0, 48'h123_456_789_ABC, 48'h111_111_111_111, 1'b0, 1'b0, 2, 3, 99, 1'b1,
           48'h234_567_89A_BCD, 1'b0, 1'b0);
    idle(2, 1'b0);
    // Restart: two chunks of an abandoned operation, then a fresh chunk 0 in place of chunk 2.
    run_op(0, 48'hAAA_BBB_CCC_DDD, 48'h999_999_999_999, 1'b0, 1'b0, 0, 0, 2, 1'b0, 48'h0, 1'b0, 1'b0);
    run_op(0, 48'h000_000_000_010, 48'h000_000_000_020, 1'b0, 1'b0, 0, 0, 99, 1'b1,
           48'h000_000_000_030, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Async reset after chunk 1 has been sampled.
    run_op(0, 48'h111_222_333_444, 48'h555_666_777_888, 1'b0, 1'b0, 0, 0, 2, 1'b0, 48'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("busy_before_rst", 64'(bz0), 64'd1);
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 48'h0, 48'h0);
    #2 rst = 1'b1;
    #1;
    check("rst_imm_out", 64'(out0), 64'd0);
    check("rst_imm_flags", {60'd0, co0, ov0, rr0, bz0}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(5, 1'b0);
    run_op(0, 48'hFFF_000_FFF_000, 48'h001_FFF_001_001, 1'b0, 1'b1, 0, 0, 99, 1'b1,
           48'h001_000_000_002, 1'b1, 1'b0);
    idle(2, 1'b0);

    // Parameter sweep: 4x6 back-to-back with occasional gaps, then 8x1 back-to-back.
    for (int t = 0; t < 40; t++) begin
      int ga = (t % 7 == 3) ? int'($urandom_range(1, 5)) : 99;
      run_model(2, pick(24), pick(24), 1'($urandom), 1'($urandom), ga, int'($urandom_range(1, 3)));
    end
    idle(3, 1'b0);
    for (int t = 0; t < 30; t++)
      run_model(1, pick(8), pick(8), 1'($urandom), 1'($urandom), 99, 0);
    idle(3, 1'b0);

    check("pending_results", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
